mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the CPU/loader RAM arbiter.
// Optional MEM_ARB_PERF_EN adds grant and stall counters to the top.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arbState_t;

    typedef enum logic {
        OWNER_CPU,
        OWNER_LD
    } owner_t;

    localparam int ADDR_W        = 11;
    localparam int DATA_W        = 64;
    localparam int ACCESS_CYCLES = 2;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-input round-robin picker; req[0] is the CPU, req[1] the loader.
// A tie goes to the port that did not win last time.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     lastWinner,
    output logic       grantValid,
    output owner_t     winner
);

    always_comb begin
        grantValid = |req;
        winner     = OWNER_CPU;
        unique case (1'b1)
            (req == 2'b10): winner = OWNER_LD;
            (req == 2'b11): winner = (lastWinner == OWNER_CPU) ? OWNER_LD
                                                               : OWNER_CPU;
            default:        winner = OWNER_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto the unified RAM.
// Define MEM_ARB_PERF_EN for grant/stall performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = mem_arb_pkg::ADDR_W,
    parameter int DATA_W        = mem_arb_pkg::DATA_W,
    parameter int ACCESS_CYCLES = mem_arb_pkg::ACCESS_CYCLES
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int PERF_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic              cpuAck,
    output logic [DATA_W-1:0] cpuRData,

    input  logic              ldReq,
    input  logic              ldWe,
    input  logic [ADDR_W-1:0] ldAddr,
    input  logic [DATA_W-1:0] ldWData,
    output logic              ldAck,
    output logic [DATA_W-1:0] ldRData,

    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramIsReading,
    output logic [DATA_W-1:0] ramDataIn,
    input  logic [DATA_W-1:0] ramDataOut,

    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] cpuGrantCount,
    output logic [PERF_W-1:0] ldGrantCount,
    output logic [PERF_W-1:0] stallCount
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arbState_t         state;
    owner_t            ownerQ;
    owner_t            lastWinner;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [CNT_W-1:0]  cnt;

    logic              grantValid;
    owner_t            winner;
    logic              lastCycle;

    mem_arb_rr_pick uPick (
        .req        ({ldReq, cpuReq}),
        .lastWinner (lastWinner),
        .grantValid (grantValid),
        .winner     (winner)
    );

    assign lastCycle = (state == ACCESS) && (cnt == '0);

    // Write strobe lives only in the final access cycle; reset drops it at once.
    assign ramIsReading = !(lastCycle && weQ);
    assign ramAddress   = addrQ;
    assign ramDataIn    = wdataQ;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ownerQ     <= OWNER_CPU;
            lastWinner <= OWNER_LD;
            weQ        <= 1'b0;
            addrQ      <= '0;
            wdataQ     <= '0;
            cnt        <= '0;
            cpuAck     <= 1'b0;
            ldAck      <= 1'b0;
            cpuRData   <= '0;
            ldRData    <= '0;
        end else begin
            cpuAck <= 1'b0;
            ldAck  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grantValid) begin
                        ownerQ     <= winner;
                        lastWinner <= winner;
                        cnt        <= CNT_LOAD;
                        state      <= ACCESS;
                        if (winner == OWNER_LD) begin
                            weQ    <= ldWe;
                            addrQ  <= ldAddr;
                            wdataQ <= ldWData;
                        end else begin
                            weQ    <= cpuWe;
                            addrQ  <= cpuAddr;
                            wdataQ <= cpuWData;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RESP;
                        if (ownerQ == OWNER_LD) begin
                            ldAck <= 1'b1;
                            if (!weQ) ldRData <= ramDataOut;
                        end else begin
                            cpuAck <= 1'b1;
                            if (!weQ) cpuRData <= ramDataOut;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic cpuGrant;
    logic ldGrant;
    logic stall;

    assign cpuGrant = (state == IDLE) && grantValid && (winner == OWNER_CPU);
    assign ldGrant  = (state == IDLE) && grantValid && (winner == OWNER_LD);
    assign stall    = (state == IDLE) ? (cpuReq && ldReq)
                    : ((ownerQ == OWNER_CPU) ? ldReq : cpuReq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpuGrantCount <= '0;
            ldGrantCount  <= '0;
            stallCount    <= '0;
        end else begin
            if (cpuGrant && (cpuGrantCount != '1))
                cpuGrantCount <= cpuGrantCount + 1'b1;
            if (ldGrant && (ldGrantCount != '1))
                ldGrantCount <= ldGrantCount + 1'b1;
            if (stall && (stallCount != '1))
                stallCount <= stallCount + 1'b1;
        end
    end
`endif

endmodule
